syn_gpu_line_raster: RTL

Bresenham line rasteriser for the Synesthesia GPU. It consumes one GPU job at a time from the job issuer, using the job fields of the shared GPU package (shape, x1/y1, x2/y2, color). For LINE jobs it emits one pixel write per cycle toward the frame-buffer writer. It is the consumer end of the GPU job interface and sits between the job queue and the pixel/SRAM arbiter.

---
 rtl/syn_gpu_line_raster_pkg.sv | 49 ++++
 rtl/syn_gpu_line_raster_bres_step.sv | 33 +++
 rtl/syn_gpu_line_raster.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/syn_gpu_line_raster_pkg.sv
// Shared GPU package: canvas geometry, job/pixel types and raster FSM state encoding.
package syn_gpu_line_raster_pkg;

  localparam int P_CANVAS_W = 640;
  localparam int P_CANVAS_H = 480;
  localparam int P_X_W      = $clog2(P_CANVAS_W);
  localparam int P_Y_W      = $clog2(P_CANVAS_H);
  localparam int P_RGB_RES  = 4;

  typedef struct packed {
    logic [P_RGB_RES-1:0] red;
    logic [P_RGB_RES-1:0] green;
    logic [P_RGB_RES-1:0] blue;
  } pxl_t;

  typedef enum logic [1:0] {
    SHAPE_LINE   = 2'd0,
    SHAPE_CIRCLE = 2'd1
  } shape_t;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_DRAW  = 2'd1,
    ACT_CLEAR = 2'd2
  } action_t;

  typedef struct packed {
    shape_t           shape;
    logic [P_X_W-1:0] x1;
    logic [P_Y_W-1:0] y1;
    logic [P_X_W-1:0] x2;
    logic [P_Y_W-1:0] y2;
    pxl_t             color;
  } job_t;

  typedef struct packed {
    logic [P_X_W-1:0] x;
    logic [P_Y_W-1:0] y;
    pxl_t             color;
    logic             last;
  } pxl_wr_t;

  typedef enum logic [1:0] {
    RST_IDLE  = 2'd0,
    RST_SETUP = 2'd1,
    RST_DRAW  = 2'd2
  } raster_st_t;

endpackage

// File: rtl/syn_gpu_line_raster_bres_step.sv
// Combinational Bresenham step: one error-term update and coordinate advance.
module syn_gpu_bres_step #(
  parameter int P_X_W = 10,
  parameter int P_Y_W = 9,
  parameter int W     = 12
) (
  input  logic signed [W-1:0] i_err,
  input  logic signed [W-1:0] i_dx,
  input  logic signed [W-1:0] i_dy,
  input  logic                i_sx_neg,
  input  logic                i_sy_neg,
  input  logic [P_X_W-1:0]    i_x,
  input  logic [P_Y_W-1:0]    i_y,
  output logic signed [W-1:0] o_err,
  output logic [P_X_W-1:0]    o_x,
  output logic [P_Y_W-1:0]    o_y
);
  import syn_gpu_line_raster_pkg::*;

  logic signed [W:0] w_e2;
  logic              w_step_x;
  logic              w_step_y;

  // e2 needs one extra bit so 2*err cannot overflow the working width
  assign w_e2     = $signed({i_err, 1'b0});
  assign w_step_x = w_e2 >= $signed({i_dy[W-1], i_dy});
  assign w_step_y = w_e2 <= $signed({i_dx[W-1], i_dx});

  assign o_err = i_err + (w_step_x ? i_dy : '0) + (w_step_y ? i_dx : '0);
  assign o_x   = w_step_x ? (i_sx_neg ? i_x - P_X_W'(1) : i_x + P_X_W'(1)) : i_x;
  assign o_y   = w_step_y ? (i_sy_neg ? i_y - P_Y_W'(1) : i_y + P_Y_W'(1)) : i_y;

endmodule

// File: rtl/syn_gpu_line_raster.sv
// Bresenham line rasteriser: one LINE job in, one pixel write per cycle out.
// SYN_GPU_RASTER_STATS_EN adds pixel/job handshake counters.
module syn_gpu_line_raster #(
  parameter int P_X_W     = syn_gpu_line_raster_pkg::P_X_W,
  parameter int P_Y_W     = syn_gpu_line_raster_pkg::P_Y_W,
  parameter int P_RGB_RES = syn_gpu_line_raster_pkg::P_RGB_RES
) (
  input  logic                   clk_ir,
  input  logic                   rst_il,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [1:0]             job_shape_i,
  input  logic [P_X_W-1:0]       job_x1_i,
  input  logic [P_Y_W-1:0]       job_y1_i,
  input  logic [P_X_W-1:0]       job_x2_i,
  input  logic [P_Y_W-1:0]       job_y2_i,
  input  logic [3*P_RGB_RES-1:0] job_color_i,
  output logic                   pxl_valid_o,
  input  logic                   pxl_ready_i,
  output logic [P_X_W-1:0]       pxl_x_o,
  output logic [P_Y_W-1:0]       pxl_y_o,
  output logic [3*P_RGB_RES-1:0] pxl_color_o,
  output logic                   pxl_last_o,
  output logic                   busy_o,
  output logic                   bad_job_o
`ifdef SYN_GPU_RASTER_STATS_EN
  ,
  output logic [31:0]            pxl_cnt_o,
  output logic [15:0]            job_cnt_o
`endif
);
  import syn_gpu_line_raster_pkg::*;

  localparam int W = ((P_X_W > P_Y_W) ? P_X_W : P_Y_W) + 2;

  localparam logic [1:0] S_IDLE  = RST_IDLE;
  localparam logic [1:0] S_SETUP = RST_SETUP;
  localparam logic [1:0] S_DRAW  = RST_DRAW;

  logic [1:0]             r_state;
  logic [P_X_W-1:0]       r_cx, r_x2;
  logic [P_Y_W-1:0]       r_cy, r_y2;
  logic [3*P_RGB_RES-1:0] r_color;
  logic signed [W-1:0]    r_dx, r_dy, r_err;
  logic                   r_sx_neg, r_sy_neg;
  logic                   r_bad;

  logic signed [W-1:0]    w_ddx, w_ddy, w_adx, w_ndy, w_nerr;
  logic [P_X_W-1:0]       w_nx;
  logic [P_Y_W-1:0]       w_ny;
  logic                   w_last, w_hs, w_job_acc;

  // ready is gated by reset so nothing is offered while the block is held in reset
  assign job_ready_o = (r_state == S_IDLE) & rst_il;
  assign w_job_acc   = job_valid_i & job_ready_o & (job_shape_i == SHAPE_LINE);
  assign w_last      = (r_cx == r_x2) && (r_cy == r_y2);
  assign w_hs        = pxl_valid_o & pxl_ready_i;

  assign pxl_valid_o = (r_state == S_DRAW);
  assign pxl_last_o  = pxl_valid_o & w_last;
  assign pxl_x_o     = r_cx;
  assign pxl_y_o     = r_cy;
  assign pxl_color_o = r_color;
  assign busy_o      = (r_state != S_IDLE);
  assign bad_job_o   = r_bad;

  // r_cx/r_cy hold the start point during SETUP
  assign w_ddx = $signed({{(W-P_X_W){1'b0}}, r_x2}) - $signed({{(W-P_X_W){1'b0}}, r_cx});
  assign w_ddy = $signed({{(W-P_Y_W){1'b0}}, r_y2}) - $signed({{(W-P_Y_W){1'b0}}, r_cy});
  assign w_adx = w_ddx[W-1] ? -w_ddx : w_ddx;
  assign w_ndy = w_ddy[W-1] ? w_ddy : -w_ddy;

  syn_gpu_bres_step #(.P_X_W(P_X_W), .P_Y_W(P_Y_W), .W(W)) u_step (
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .i_x      (r_cx),
    .i_y      (r_cy),
    .o_err    (w_nerr),
    .o_x      (w_nx),
    .o_y      (w_ny)
  );

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_state  <= S_IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x2     <= '0;
      r_y2     <= '0;
      r_color  <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_job_acc) begin
            r_cx    <= job_x1_i;
            r_cy    <= job_y1_i;
            r_x2    <= job_x2_i;
            r_y2    <= job_y2_i;
            r_color <= job_color_i;
            r_state <= S_SETUP;
          end else if (job_valid_i) begin
            r_bad <= 1'b1;
          end
        end
        S_SETUP: begin
          r_dx     <= w_adx;
          r_dy     <= w_ndy;
          r_err    <= w_adx + w_ndy;
          r_sx_neg <= !(r_cx < r_x2);
          r_sy_neg <= !(r_cy < r_y2);
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          if (w_hs) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_err <= w_nerr;
              r_cx  <= w_nx;
              r_cy  <= w_ny;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SYN_GPU_RASTER_STATS_EN
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pxl_cnt_o <= '0;
      job_cnt_o <= '0;
    end else begin
      if (w_hs)      pxl_cnt_o <= pxl_cnt_o + 32'd1;
      if (w_job_acc) job_cnt_o <= job_cnt_o + 16'd1;
    end
  end
`endif

endmodule
